// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and its datapath.
// The datapath (master) drives the instruction fields and the ALU zero flag;
// the controller (slave) returns every control select, enable and status.
interface multicycle_controller_if;

    // Instruction fields and datapath status
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;

    // Control outputs
    logic        PCSrc;
    logic        AdrSrc;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA1;
    logic [1:0]  ALUSrcB1;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;

    // Status / debug
    logic [3:0]  state_o;
    logic [31:0] instr_count;
    logic        illegal;

    // Datapath side
    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCSrc, AdrSrc, IRWrite, RegWrite, MemWrite,
        input  ResultSrc, ALUSrcA1, ALUSrcB1, ImmSrc, ALUControl,
        input  state_o, instr_count, illegal
    );

    // Controller side
    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCSrc, AdrSrc, IRWrite, RegWrite, MemWrite,
        output ResultSrc, ALUSrcA1, ALUSrcB1, ImmSrc, ALUControl,
        output state_o, instr_count, illegal
    );

endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: a Moore main FSM, an ALU decoder and an
// immediate-format decoder. PCSrc is the only Mealy output (it folds in Zero
// for taken branches). Also keeps a retired-instruction counter and a sticky
// illegal-opcode flag. All write enables are combinationally gated by reset so
// an asserted reset silences the datapath immediately.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,   // asynchronous, active low
    multicycle_controller_if.slave  bus
);

    // Opcodes understood by the decoder
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    // What the main FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        illegal_q, illegal_d;

    // Raw (ungated) per-state controls
    logic        pc_write;
    logic        branch;
    logic        adr_src;
    logic        ir_write;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [1:0]  src_a;
    logic [1:0]  src_b;
    logic        named_state;
    aluop_t      alu_op;
    logic [3:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic        op_legal;
    logic        retire;

    // Opcode legality check used by DECODE
    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
            default:                                  op_legal = 1'b0;
        endcase
    end

    // State, retired count and illegal flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            count_q   <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and Moore control outputs for the current state
    always_comb begin
        state_d     = FETCH;
        pc_write    = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        result_src  = 2'b00;
        src_a       = 2'b00;
        src_b       = 2'b00;
        alu_op      = ALUOP_NONE;
        named_state = 1'b1;
        case (state_q)
            FETCH: begin
                adr_src    = 1'b0;
                ir_write   = 1'b1;
                src_a      = 2'b00;
                src_b      = 2'b10;
                alu_op     = ALUOP_ADD;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                // Precompute the branch target from the old PC
                src_a  = 2'b01;
                src_b  = 2'b01;
                alu_op = ALUOP_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = ALUOP_ADD;
                state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                result_src = 2'b00;
                adr_src    = 1'b1;
                state_d    = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                result_src = 2'b00;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_d    = FETCH;
            end
            EXECUTER: begin
                src_a   = 2'b10;
                src_b   = 2'b00;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                src_a      = 2'b10;
                src_b      = 2'b00;
                alu_op     = ALUOP_SUB;
                result_src = 2'b00;
                branch     = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                // Link value old PC + 4; PC takes the target computed in DECODE
                src_a      = 2'b01;
                src_b      = 2'b10;
                alu_op     = ALUOP_ADD;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = ALUWB;
            end
            default: begin
                // Unused encodings recover to FETCH with everything quiet
                named_state = 1'b0;
                state_d     = FETCH;
            end
        endcase
    end

    // ALU decoder: fixed add/sub, or an operation chosen by funct3/funct7
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (bus.funct3)
                    3'b000:  alu_ctrl = (bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_ADD;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default:   alu_ctrl = ALU_ADD;
        endcase
    end

    // Immediate format from the opcode alone
    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Retirement happens on the edge leaving a final state of a legal instruction
    always_comb begin
        retire    = (state_q == MEMWB) || (state_q == MEMWRITE) ||
                    (state_q == ALUWB) || (state_q == BEQ);
        count_d   = retire ? count_q + 32'd1 : count_q;
        illegal_d = illegal_q || ((state_q == DECODE) && !op_legal);
    end

    // Enables are gated by reset so an asserted reset aborts writes at once
    assign bus.PCSrc      = reset & (pc_write | (branch & bus.Zero));
    assign bus.IRWrite    = reset & ir_write;
    assign bus.RegWrite   = reset & reg_write;
    assign bus.MemWrite   = reset & mem_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA1   = src_a;
    assign bus.ALUSrcB1   = src_b;
    assign bus.ImmSrc     = named_state ? imm_src : 2'b00;
    assign bus.ALUControl = alu_ctrl;
    assign bus.state_o    = state_q;
    assign bus.instr_count = count_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions followed by random
// ones, checked against a table-driven reference of each instruction's
// state walk and per-state control word.
module tb_multicycle_controller;

    logic clk;
    logic reset;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef int int_q_t[$];

    typedef struct packed {
        logic       pcsrc;
        logic       adrsrc;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] alu;
    } ctl_t;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state
    logic [31:0] m_count;
    logic        m_illegal;

    logic [6:0] legal_ops [6];
    logic [6:0] bad_ops   [5];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Walk of states an instruction visits, starting at FETCH
    function automatic int_q_t seq_for(input logic [6:0] o);
        case (o)
            7'b0000011: return '{0, 1, 2, 3, 4};
            7'b0100011: return '{0, 1, 2, 5};
            7'b0110011: return '{0, 1, 6, 8};
            7'b0010011: return '{0, 1, 7, 8};
            7'b1100011: return '{0, 1, 9};
            7'b1101111: return '{0, 1, 10, 8};
            default:    return '{0, 1};
        endcase
    endfunction

    function automatic logic [3:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0: return (o[5] && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd6;
            3'd2: return 4'd5;
            3'd3: return 4'd0;
            3'd4: return 4'd4;
            3'd5: return 4'd7;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Control word each state should present
    function automatic ctl_t ctl_ref(input int s, input logic [6:0] o, input logic [2:0] f3,
                                     input logic f7, input logic z);
        ctl_t c;
        c = '0;
        case (s)
            0:  begin c.irwrite = 1; c.sb = 2; c.res = 2; c.pcsrc = 1; end
            1:  begin c.sa = 1; c.sb = 1; end
            2:  begin c.sa = 2; c.sb = 1; end
            3:  begin c.adrsrc = 1; end
            4:  begin c.res = 1; c.regwrite = 1; end
            5:  begin c.adrsrc = 1; c.memwrite = 1; end
            6:  begin c.sa = 2; c.alu = alu_ref(o, f3, f7); end
            7:  begin c.sa = 2; c.sb = 1; c.alu = alu_ref(o, f3, f7); end
            8:  begin c.regwrite = 1; end
            9:  begin c.sa = 2; c.alu = 4'd1; c.pcsrc = z; end
            10: begin c.sa = 1; c.sb = 2; c.pcsrc = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check_ctl(input ctl_t e, input int s);
        string t;
        t = $sformatf("s%0d", s);
        chk({t, ".PCSrc"},      32'(bus.PCSrc),      32'(e.pcsrc));
        chk({t, ".AdrSrc"},     32'(bus.AdrSrc),     32'(e.adrsrc));
        chk({t, ".IRWrite"},    32'(bus.IRWrite),    32'(e.irwrite));
        chk({t, ".RegWrite"},   32'(bus.RegWrite),   32'(e.regwrite));
        chk({t, ".MemWrite"},   32'(bus.MemWrite),   32'(e.memwrite));
        chk({t, ".ResultSrc"},  32'(bus.ResultSrc),  32'(e.res));
        chk({t, ".ALUSrcA1"},   32'(bus.ALUSrcA1),   32'(e.sa));
        chk({t, ".ALUSrcB1"},   32'(bus.ALUSrcB1),   32'(e.sb));
        chk({t, ".ALUControl"}, 32'(bus.ALUControl), 32'(e.alu));
    endtask

    task automatic check_enables_off(input string tag);
        chk({tag, ".PCSrc"},    32'(bus.PCSrc),    32'd0);
        chk({tag, ".IRWrite"},  32'(bus.IRWrite),  32'd0);
        chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'd0);
        chk({tag, ".MemWrite"}, 32'(bus.MemWrite), 32'd0);
    endtask

    // Runs one instruction from FETCH back to FETCH; called 1 time unit after an edge
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        int_q_t seq;
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
        #1;
        seq = seq_for(o);
        foreach (seq[i]) begin
            chk("state", 32'(bus.state_o), 32'(seq[i]));
            check_ctl(ctl_ref(seq[i], o, f3, f7, z), seq[i]);
            chk("ImmSrc", 32'(bus.ImmSrc), 32'(imm_ref(o)));
            chk("instr_count", bus.instr_count, m_count);
            chk("illegal", 32'(bus.illegal), 32'(m_illegal));
            @(posedge clk);
            #1;
        end
        if (is_legal(o)) m_count = m_count + 32'd1;
        else             m_illegal = 1'b1;
        chk("end.state", 32'(bus.state_o), 32'd0);
        chk("end.instr_count", bus.instr_count, m_count);
        chk("end.illegal", 32'(bus.illegal), 32'(m_illegal));
    endtask

    initial begin
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        bad_ops   = '{7'b1111111, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};
        m_count   = 32'd0;
        m_illegal = 1'b0;

        // Reset state
        reset        = 1'b0;
        bus.op       = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.Zero     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.state", 32'(bus.state_o), 32'd0);
        chk("rst.instr_count", bus.instr_count, 32'd0);
        chk("rst.illegal", 32'(bus.illegal), 32'd0);
        check_enables_off("rst");
        #2;
        reset = 1'b1;

        // Directed instructions
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);   // lw
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);   // sw
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);   // sub
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0);   // add
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);   // addi, funct7b5 ignored
        run_instr(7'b0110011, 3'd7, 1'b0, 1'b1);   // and
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);   // beq taken
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);   // beq not taken
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);   // illegal
        run_instr(7'b0110011, 3'd6, 1'b0, 1'b0);   // or, illegal must stay set
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);   // jal

        // Reset pulsed in the middle of a load, while in MEMREAD
        bus.op = 7'b0000011;
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid.state_before", 32'(bus.state_o), 32'd3);
        #2;
        reset     = 1'b0;
        m_count   = 32'd0;
        m_illegal = 1'b0;
        #1;
        chk("mid.state", 32'(bus.state_o), 32'd0);
        chk("mid.instr_count", bus.instr_count, 32'd0);
        chk("mid.illegal", 32'(bus.illegal), 32'd0);
        check_enables_off("mid");
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mid.hold_state", 32'(bus.state_o), 32'd0);
            check_enables_off("mid.hold");
        end
        reset = 1'b1;
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);   // first edge after reset runs FETCH

        // Random instructions
        for (int n = 0; n < 60; n++) begin
            int k;
            logic [6:0] o;
            k = int'($urandom_range(0, 6));
            o = (k == 6) ? bad_ops[$urandom_range(0, 4)] : legal_ops[k];
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset (0 = in reset).
REQ-002 Inputs SHALL be: op  in  7  instruction opcode [6:0]; funct3  in  3  instruction [14:12]; funct7b5  in  1  instruction bit 30; Zero  in  1  ALU zero flag.
REQ-003 Outputs SHALL be:
- PCSrc  out  1  PC register enable.
- AdrSrc  out  1  memory address select (0 = PC, 1 = Result).
- IRWrite  out  1  instruction/old-PC register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- ResultSrc  out  2  result select (00 = ALUout, 01 = memory data register, 10 = ALUResult).
- ALUSrcA1  out  2  SrcA select (00 = PC, 01 = old PC, 10 = register A).
- ALUSrcB1  out  2  SrcB select (00 = register B, 01 = ImmExt, 10 = constant 4).
- ImmSrc  out  2  immediate format (00 = I, 01 = S, 10 = B, 11 = J).
- ALUControl  out  4  ALU operation.
- state_o  out  4  current state, for debug.
- instr_count  out  32  retired-instruction counter.
- illegal  out  1  sticky illegal-opcode flag.

Function
REQ-004 The FSM state encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10; the block SHALL make exactly one state transition per clock.
REQ-005 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA1=00, ALUSrcB1=10, ALU add, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-006 DECODE SHALL drive ALUSrcA1=01, ALUSrcB1=01 and ALU add (branch target), then branch on op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other op -> FETCH, with illegal set to 1.
REQ-007 MEMADR SHALL drive ALUSrcA1=10, ALUSrcB1=01 and ALU add, then go to MEMREAD if op=0000011, otherwise to MEMWRITE.
REQ-008 MEMREAD SHALL drive ResultSrc=00 and AdrSrc=1, then go to MEMWB; MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-009 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1 and MemWrite=1, then go to FETCH.
REQ-010 EXECUTER SHALL drive ALUSrcA1=10, ALUSrcB1=00 and ALUOp=funct; EXECUTEI SHALL drive ALUSrcA1=10, ALUSrcB1=01 and ALUOp=funct; both SHALL then go to ALUWB.
REQ-011 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-012 BEQ SHALL drive ALUSrcA1=10, ALUSrcB1=00, ALU sub, ResultSrc=00 and Branch=1, then go to FETCH.
REQ-013 JAL SHALL drive ALUSrcA1=01, ALUSrcB1=10, ALU add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-014 PCSrc SHALL equal PCWrite OR (Branch AND Zero), combinationally from the current state and Zero; every other output SHALL be Moore (a function of state, op and funct fields only).
REQ-015 ALUControl SHALL be encoded as: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111.
REQ-016 When ALUOp=funct, ALUControl SHALL decode funct3 as:
- 000 -> sub if op[5]=1 and funct7b5=1, otherwise add.
- 001 -> sll; 010 -> slt; 100 -> xor; 101 -> srl; 110 -> or; 111 -> and.
- 011 -> add.
REQ-017 ImmSrc SHALL be decoded combinationally from op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, all other ops -> 00.
REQ-018 In any state not named in REQ-005 to REQ-013, every enable (PCSrc, IRWrite, RegWrite, MemWrite) SHALL be 0, every select SHALL be 00 and ALUControl SHALL be 0000.
REQ-019 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-020 An illegal-op return from DECODE to FETCH SHALL NOT increment instr_count.
REQ-021 illegal SHALL stay at 1 once set, until reset.
REQ-022 Any unused state encoding (11 to 15) SHALL go to FETCH on the next clock.

Reset
REQ-023 While reset=0, the state SHALL be FETCH, instr_count SHALL be 0 and illegal SHALL be 0.
REQ-024 While reset=0, PCSrc, IRWrite, RegWrite and MemWrite SHALL be forced to 0, and these enables SHALL be gated by reset combinationally.
REQ-025 Reset asserted in the middle of an instruction SHALL abort that instruction immediately, with no further RegWrite or MemWrite.
REQ-026 The first clock edge after reset deasserts SHALL execute FETCH.

Verification
REQ-027 Stimulus op=0000011 (lw) -> states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; instr_count goes 0 -> 1.
REQ-028 Stimulus op=0100011 (sw) -> states 0,1,2,5,0; MemWrite=1 with AdrSrc=1 only in state 5; ImmSrc=01.
REQ-029 Stimulus op=0110011, funct3=000, funct7b5=1 -> ALUControl=0001 in state 6; with funct7b5=0 -> ALUControl=0000; op=0010011, funct3=000, funct7b5=1 -> ALUControl=0000.
REQ-030 Stimulus op=1100011 in BEQ with Zero=1 -> PCSrc=1; with Zero=0 -> PCSrc=0; the next state SHALL be FETCH in both cases.
REQ-031 Stimulus op=1111111 -> states 0,1,0; illegal=1 and stays 1; instr_count unchanged.
REQ-032 Stimulus: reset=0 pulsed asynchronously during state 3 -> state_o=0 and all enables 0 immediately, with no RegWrite afterwards; JAL (op=1101111) -> states 0,1,10,8,0, PCSrc=1 in state 10.
